// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait holds, branch redirect, multi-cycle MDU stall, load-use bubble.
// Optional performance counters are enabled with `define PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_mispredict,
  input  logic        ex_mdu_start,
  input  logic        mdu_done,
  input  logic        im_ready,
  input  logic        dm_req,
  input  logic        dm_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        id_ex_hold,
  output logic        ex_mem_bubble,
  output logic        ex_mem_hold,
  output logic        mem_wb_hold,
  output logic        redirect,
  output logic [1:0]  state,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  state_e cur_state, nxt_state, ret_state, nxt_ret, eff_state;
  logic   pend_redirect, nxt_pend;
  logic   mem_busy, load_use, redir_fire;

  assign mem_busy  = (~im_ready) | (dm_req & ~dm_ready);
  assign load_use  = ex_is_load & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  // The cycle that releases a memory wait behaves like the state the wait interrupted.
  assign eff_state  = (cur_state == MEM_WAIT) ? ret_state : cur_state;
  assign redir_fire = pend_redirect | (ex_mispredict & (eff_state == RUN));
  assign state      = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state     <= RUN;
      ret_state     <= RUN;
      pend_redirect <= 1'b0;
    end else begin
      cur_state     <= nxt_state;
      ret_state     <= nxt_ret;
      pend_redirect <= nxt_pend;
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    nxt_ret       = ret_state;
    nxt_pend      = pend_redirect;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_bubble = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_hold   = 1'b0;
    redirect      = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_hold  = 1'b1;
        ex_mem_hold = 1'b1;
        mem_wb_hold = 1'b1;
        if (ex_mispredict) nxt_pend = 1'b1;
        // A pending redirect flush waits in REDIRECT until memory releases.
        case (cur_state)
          RUN: begin
            nxt_state = MEM_WAIT;
            nxt_ret   = RUN;
          end
          MDU_BUSY: begin
            nxt_state = MEM_WAIT;
            nxt_ret   = mdu_done ? RUN : MDU_BUSY;
          end
          MEM_WAIT: begin
            if ((ret_state == MDU_BUSY) && mdu_done) nxt_ret = RUN;
          end
          default: ;
        endcase
      end else if (cur_state == REDIRECT) begin
        if_id_flush = 1'b1;
        nxt_state   = RUN;
      end else if (redir_fire) begin
        redirect     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        nxt_pend     = 1'b0;
        nxt_state    = REDIRECT;
      end else if (eff_state == MDU_BUSY) begin
        if (mdu_done) begin
          nxt_state = RUN;
        end else begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_hold    = 1'b1;
          ex_mem_bubble = 1'b1;
          nxt_state     = MDU_BUSY;
        end
      end else if (ex_mdu_start) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_bubble = 1'b1;
        nxt_state     = MDU_BUSY;
      end else begin
        nxt_state = RUN;
        if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_mispredict = 0;
  logic ex_mdu_start = 0, mdu_done = 0, im_ready = 1, dm_req = 0, dm_ready = 0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold;
  logic ex_mem_bubble, ex_mem_hold, mem_wb_hold, redirect;
  logic [1:0]  state;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mispredict(ex_mispredict),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .ex_mem_hold(ex_mem_hold), .mem_wb_hold(mem_wb_hold), .redirect(redirect),
    .state(state), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  typedef struct {
    logic rst;
    logic [4:0] rs1, rs2, rd;
    logic use1, use2, is_load, misp, start, done, im_rdy, dreq, drdy;
  } stim_t;

  // ctrl order: pc_stall if_id_stall if_id_flush id_ex_bubble id_ex_hold ex_mem_bubble ex_mem_hold mem_wb_hold redirect
  typedef struct {
    int          cyc;
    logic [8:0]  ctrl;
    logic [1:0]  st;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0;

  localparam int M_RUN = 0, M_WAIT = 1, M_MDU = 2, M_REDIR = 3;
  int m_mode = M_RUN, m_ret = M_RUN;
  bit m_pend = 0;
  logic [31:0] m_sc = '0, m_fc = '0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, use1: 1'b0, use2: 1'b0, is_load: 1'b0,
          misp: 1'b0, start: 1'b0, done: 1'b0, im_rdy: 1'b1, dreq: 1'b0, drdy: 1'b0};
    return s;
  endfunction

  // Reference: what the pipeline must do this cycle, by priority of hazard classes.
  task automatic model_and_push(input stim_t s);
    exp_t e;
    bit busy, hz, stall_all, mdu_stall, lu_stall, flush_req, flush_only;
    int mode_now;
    busy = !s.im_rdy || (s.dreq && !s.drdy);
    hz = s.is_load && s.rd != 0 && ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
    if (s.rst) begin
      m_mode = M_RUN; m_ret = M_RUN; m_pend = 0; m_sc = '0; m_fc = '0;
    end
    e.cyc = cyc; e.st = 2'(m_mode); e.ctrl = '0;
    e.sc = m_sc; e.fc = m_fc;
`ifndef PIPE_HAZARD_PERF_EN
    e.sc = '0; e.fc = '0;
`endif
    stall_all = 0; mdu_stall = 0; lu_stall = 0; flush_req = 0; flush_only = 0;
    mode_now = (m_mode == M_WAIT) ? m_ret : m_mode;
    if (s.rst) begin
      // everything quiet
    end else if (busy) begin
      stall_all = 1;
      if (s.misp) m_pend = 1;
      if (m_mode == M_RUN) begin m_mode = M_WAIT; m_ret = M_RUN; end
      else if (m_mode == M_MDU) begin m_mode = M_WAIT; m_ret = s.done ? M_RUN : M_MDU; end
      else if (m_mode == M_WAIT && m_ret == M_MDU && s.done) m_ret = M_RUN;
    end else if (m_mode == M_REDIR) begin
      flush_only = 1; m_mode = M_RUN;
    end else if (m_pend || (s.misp && mode_now == M_RUN)) begin
      flush_req = 1; m_pend = 0; m_mode = M_REDIR;
    end else if (mode_now == M_MDU) begin
      if (s.done) m_mode = M_RUN;
      else begin mdu_stall = 1; m_mode = M_MDU; end
    end else if (s.start) begin
      mdu_stall = 1; m_mode = M_MDU;
    end else begin
      m_mode = M_RUN;
      lu_stall = hz;
    end
    e.ctrl = {stall_all || mdu_stall || lu_stall,
              stall_all || mdu_stall || lu_stall,
              flush_req || flush_only,
              flush_req || lu_stall,
              stall_all || mdu_stall,
              mdu_stall,
              stall_all,
              stall_all,
              flush_req};
    if (e.ctrl[8] && !s.rst && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
    if (e.ctrl[0] && !s.rst && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
    sb.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2; ex_is_load = s.is_load;
    ex_mispredict = s.misp; ex_mdu_start = s.start; mdu_done = s.done;
    im_ready = s.im_rdy; dm_req = s.dreq; dm_ready = s.drdy;
    cyc++;
    model_and_push(s);
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [8:0] act;
      e = sb.pop_front();
      act = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold,
             ex_mem_bubble, ex_mem_hold, mem_wb_hold, redirect};
      checks++;
      if (act !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl cyc=%0d actual=%b required=%b", e.cyc, act, e.ctrl);
      end
      checks++;
      if (state !== e.st) begin
        failures++;
        $display("FAIL state cyc=%0d actual=%0d required=%0d", e.cyc, state, e.st);
      end
      checks++;
      if (perf_stall_cnt !== e.sc) begin
        failures++;
        $display("FAIL stall_cnt cyc=%0d actual=%0d required=%0d", e.cyc, perf_stall_cnt, e.sc);
      end
      checks++;
      if (perf_flush_cnt !== e.fc) begin
        failures++;
        $display("FAIL flush_cnt cyc=%0d actual=%0d required=%0d", e.cyc, perf_flush_cnt, e.fc);
      end
    end
  end

  initial begin
    stim_t s;
    int wait_cyc;
    // reset
    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);
    apply(idle());
    // load-use on rs1
    s = idle(); s.is_load = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1;
    apply(s); apply(idle());
    // load-use on rs2, and a source not actually read
    s = idle(); s.is_load = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.use2 = 1;
    apply(s);
    s.use2 = 0; apply(s);
    // load to x0
    s = idle(); s.is_load = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.use1 = 1;
    apply(s);
    // mispredict pulse
    s = idle(); s.misp = 1; apply(s);
    apply(idle()); apply(idle());
    // mispredict together with load-use: flush only
    s = idle(); s.misp = 1; s.is_load = 1; s.rd = 5'd3; s.rs1 = 5'd3; s.use1 = 1;
    apply(s); apply(idle()); apply(idle());
    // MDU with done four cycles later
    s = idle(); s.start = 1; apply(s);
    repeat (3) apply(idle());
    s = idle(); s.done = 1; apply(s);
    apply(idle());
    // mispredict during a data-memory wait
    s = idle(); s.dreq = 1; s.drdy = 0; s.misp = 1; apply(s);
    s.misp = 0; apply(s); apply(s);
    apply(idle()); apply(idle()); apply(idle());
    // instruction fetch stall inside MDU_BUSY
    s = idle(); s.start = 1; apply(s);
    s = idle(); s.im_rdy = 0; apply(s); apply(s);
    apply(idle());
    s = idle(); s.done = 1; apply(s);
    apply(idle());
    // reset while MDU busy
    s = idle(); s.start = 1; apply(s);
    apply(idle());
    s = idle(); s.rst = 1; apply(s); apply(s);
    apply(idle()); apply(idle());
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(0, 199) == 0);
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 3));
      s.use1    = 1'($urandom_range(0, 1));
      s.use2    = 1'($urandom_range(0, 1));
      s.is_load = ($urandom_range(0, 9) < 4);
      s.misp    = ($urandom_range(0, 9) == 0);
      s.start   = ($urandom_range(0, 9) == 0);
      s.done    = ($urandom_range(0, 9) < 3);
      s.im_rdy  = ($urandom_range(0, 9) != 0);
      s.dreq    = ($urandom_range(0, 9) < 3);
      s.drdy    = ($urandom_range(0, 9) < 6);
      apply(s);
    end
    apply(idle());
    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, clock; rst input 1, asynchronous active-high reset.
REQ-002 SHALL have ports:
- id_rs1, id_rs2, input 5 each: ID source registers.
- id_use_rs1, id_use_rs2, input 1 each: the ID instruction reads that source.
- ex_rd, input 5: EX destination register.
- ex_is_load, input 1: EX holds a load.
REQ-003 SHALL have ports:
- ex_mispredict, input 1: EX resolved a wrong branch or jump prediction.
- ex_mdu_start, input 1: EX issues a multi-cycle mul/div.
- mdu_done, input 1: mul/div result ready.
REQ-004 SHALL have ports:
- im_ready, input 1: instruction fetch completes this cycle.
- dm_req, input 1: MEM stage accesses data memory.
- dm_ready, input 1: data access completes this cycle.
REQ-005 SHALL have outputs, 1 bit each:
- pc_stall, if_id_stall, if_id_flush.
- id_ex_bubble: ID/EX loads a NOP (addi x0, all prediction fields 0).
- id_ex_hold: ID/EX keeps its value.
- ex_mem_bubble, ex_mem_hold, mem_wb_hold.
- redirect: PC takes the EX target.
REQ-006 SHALL have outputs:
- state, output 2: FSM state.
- perf_stall_cnt, output 32: stall-cycle counter.
- perf_flush_cnt, output 32: flush counter.

Function
REQ-007 SHALL implement the FSM states RUN=0, MEM_WAIT=1, MDU_BUSY=2, REDIRECT=3, held in a register clocked by clk.
REQ-008 SHALL define mem_busy = (!im_ready) | (dm_req & !dm_ready), evaluated combinationally every cycle.
REQ-009 SHALL assert all hold/stall outputs (pc_stall, if_id_stall, id_ex_hold, ex_mem_hold, mem_wb_hold) in any cycle with mem_busy=1, and no bubble/flush output, in any state; priority 1.
REQ-010 SHALL move RUN to MEM_WAIT when mem_busy=1, and MEM_WAIT to the saved return state (RUN or MDU_BUSY) in the first cycle with mem_busy=0.
REQ-011 SHALL, in RUN with ex_mdu_start=1 and mem_busy=0:
- assert pc_stall, if_id_stall, id_ex_hold and ex_mem_bubble;
- enter MDU_BUSY.
REQ-012 SHALL, in MDU_BUSY:
- repeat the outputs of REQ-011 until mdu_done=1;
- in the mdu_done cycle, release all holds and return to RUN (zero-cycle completion penalty).
REQ-013 SHALL, when ex_mispredict=1 in RUN with mem_busy=0, in that cycle:
- assert redirect, if_id_flush and id_ex_bubble;
- enter REDIRECT for exactly 1 cycle, asserting if_id_flush only;
- then return to RUN.
REQ-014 SHALL latch ex_mispredict into pending_redirect when it occurs while mem_busy=1, and perform REQ-013 on the first cycle mem_busy=0; pending_redirect clears then.
REQ-015 SHALL detect load-use in RUN as: ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-016 SHALL, on load-use, for one cycle:
- assert pc_stall, if_id_stall and id_ex_bubble;
- leave the FSM in RUN.
REQ-017 SHALL use the priority mem_busy > mispredict/pending_redirect > mdu start/busy > load-use; a mispredict and a load-use in the same cycle yield flush only, with no stall.
REQ-018 SHALL never assert a hold and a bubble/flush on the same pipeline register in one cycle.
REQ-019 SHALL produce all control outputs combinationally from state, pending_redirect and inputs, with zero-cycle latency.

Reset
REQ-020 SHALL, while rst=1, hold state=RUN, pending_redirect=0, return-state=RUN, both counters 0, and force every 1-bit control output to 0.
REQ-021 SHALL, when rst is asserted mid-MEM_WAIT, mid-MDU_BUSY or mid-REDIRECT, abandon the operation immediately and resume in RUN on the first clock edge after deassertion.

Configuration
REQ-022 SHALL, with PIPE_HAZARD_PERF_EN defined:
- increment perf_stall_cnt in every cycle pc_stall=1;
- increment perf_flush_cnt in every cycle redirect=1;
- saturate both counters at 0xFFFFFFFF.
REQ-023 SHALL, with PIPE_HAZARD_PERF_EN undefined, keep both counter ports present and tie them to 0 with no counter flops.

Verification
REQ-024 SHALL cover load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_stall=1 and id_ex_bubble=1, state stays 0.
REQ-025 SHALL cover a load to x0: ex_rd=0, id_rs1=0, ex_is_load=1 -> no stall.
REQ-026 SHALL cover mispredict: ex_mispredict pulse in RUN -> redirect=1 with if_id_flush in cycle N; if_id_flush only in N+1 (state=3); RUN in N+2; perf_flush_cnt=1 with the macro defined.
REQ-027 SHALL cover MDU: ex_mdu_start then mdu_done 4 cycles later -> pc_stall=1 for 4 cycles, ex_mem_bubble=1 throughout, RUN in the mdu_done cycle; perf_stall_cnt=4.
REQ-028 SHALL cover mispredict under memory wait: dm_req=1, dm_ready=0 for 3 cycles with ex_mispredict in cycle 1 -> all holds for 3 cycles, redirect=1 in cycle 4.
REQ-029 SHALL cover reset mid-MDU_BUSY: rst pulse -> state=0 and all control outputs 0 during reset.
